// File: rtl/nibble_serial_sub_if.sv
// nibble_serial_sub_if: operand/result handshake bundle for nibble_serial_sub.
//   master : operand producer / result consumer (drives in_valid, a, b, out_ready)
//   slave  : the subtractor (drives in_ready, out_valid, diff, borrow[, zero, ovf])
// Optional macro NSUB_FLAGS_EN adds the zero/ovf result flags.
interface nibble_serial_sub_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow;
`ifdef NSUB_FLAGS_EN
  logic             zero;
  logic             ovf;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, diff, borrow, zero, ovf
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, diff, borrow, zero, ovf
  );
`else
  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, diff, borrow
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, diff, borrow
  );
`endif
endinterface

// File: rtl/nibble_serial_sub.sv
// nibble_serial_sub: multi-cycle subtractor, diff = a - b, four bits per clock
// through a single 4-bit carry-lookahead slice computing a + ~b + 1.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    nibble_serial_sub_if.slave: in_valid/in_ready/a/b operand handshake,
//          out_valid/out_ready/diff/borrow result handshake (+ zero/ovf)
// Optional macro NSUB_FLAGS_EN: adds registered zero and signed-overflow flags.
// WIDTH must be a multiple of 4 and at least 4; latency is WIDTH/4 cycles.
module nibble_serial_sub #(
  parameter int unsigned WIDTH = 32
) (
  input logic               clk,
  input logic               rst_n,
  nibble_serial_sub_if.slave bus
);

  localparam int unsigned N    = WIDTH / 4;
  localparam int unsigned CW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;        // holds ~b
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
`ifdef NSUB_FLAGS_EN
  logic             nz_q, nz_d;       // any nonzero sum nibble seen so far
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
`endif

  // 4-bit carry-lookahead slice on the low nibbles of A and ~B
  logic [3:0] g_c, p_c, sum_c;
  logic       c1_c, c2_c, c3_c, cout_c;

  assign g_c  = a_q[3:0] & b_q[3:0];
  assign p_c  = a_q[3:0] ^ b_q[3:0];
  assign c1_c = g_c[0] | (p_c[0] & carry_q);
  assign c2_c = g_c[1] | (p_c[1] & g_c[0]) | (p_c[1] & p_c[0] & carry_q);
  assign c3_c = g_c[2] | (p_c[2] & g_c[1]) | (p_c[2] & p_c[1] & g_c[0])
              | (p_c[2] & p_c[1] & p_c[0] & carry_q);
  assign cout_c = g_c[3] | (p_c[3] & g_c[2]) | (p_c[3] & p_c[2] & g_c[1])
                | (p_c[3] & p_c[2] & p_c[1] & g_c[0])
                | (p_c[3] & p_c[2] & p_c[1] & p_c[0] & carry_q);
  assign sum_c = p_c ^ {c3_c, c2_c, c1_c, carry_q};

  // Next-state and datapath control
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    diff_d      = diff_q;
    borrow_d    = borrow_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
`ifdef NSUB_FLAGS_EN
    nz_d        = nz_q;
    a_msb_d     = a_msb_q;
    b_msb_d     = b_msb_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          state_d    = S_RUN;
          a_d        = bus.a;
          b_d        = ~bus.b;
          carry_d    = 1'b1;
          cnt_d      = '0;
          diff_d     = '0;
          in_ready_d = 1'b0;
`ifdef NSUB_FLAGS_EN
          nz_d       = 1'b0;
          a_msb_d    = bus.a[WIDTH-1];
          b_msb_d    = bus.b[WIDTH-1];
`endif
        end
      end

      S_RUN: begin
        // Sum nibble enters at the MSB side so nibble 0 ends up at diff[3:0]
        diff_d  = (diff_q >> 4) | (WIDTH'(sum_c) << (WIDTH - 4));
        a_d     = a_q >> 4;
        b_d     = b_q >> 4;
        carry_d = cout_c;
        cnt_d   = cnt_q + CW'(1);
`ifdef NSUB_FLAGS_EN
        nz_d    = nz_q | (|sum_c);
`endif
        if (cnt_q == LAST) begin
          state_d     = S_DONE;
          out_valid_d = 1'b1;
          borrow_d    = ~cout_c;
`ifdef NSUB_FLAGS_EN
          zero_d      = ~(nz_q | (|sum_c));
          // Final sum nibble MSB is the result sign bit
          ovf_d       = (a_msb_q != b_msb_q) && (sum_c[3] != a_msb_q);
`endif
        end
      end

      S_DONE: begin
        if (out_valid_q && bus.out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end

      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b1;
      cnt_q       <= '0;
      diff_q      <= '0;
      borrow_q    <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef NSUB_FLAGS_EN
      nz_q        <= 1'b0;
      a_msb_q     <= 1'b0;
      b_msb_q     <= 1'b0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      diff_q      <= diff_d;
      borrow_q    <= borrow_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
`ifdef NSUB_FLAGS_EN
      nz_q        <= nz_d;
      a_msb_q     <= a_msb_d;
      b_msb_q     <= b_msb_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.diff      = diff_q;
  assign bus.borrow    = borrow_q;
`ifdef NSUB_FLAGS_EN
  assign bus.zero      = zero_q;
  assign bus.ovf       = ovf_q;
`endif

endmodule

// File: doc/nibble_serial_sub.md
# nibble_serial_sub

Multi-cycle unsigned/two's-complement subtractor for the FPU datapath. It computes `diff = a - b` on WIDTH-bit operands four bits per clock, using a single 4-bit carry-lookahead slice on `a + ~b + 1`. It is the subtract counterpart to the combinational CLA adder. It sits in the exponent-difference and mantissa-alignment path, where area matters more than latency. Operands enter and results leave on valid/ready handshakes.

## Interface
- `WIDTH`, default 32: operand width in bits; must be a multiple of 4 and at least 4. N = WIDTH/4 nibble steps.
- `clk`  input  1  rising-edge clock; the block's only clock.
- `rst_n`  input  1  reset, asynchronous and active-low.
- `in_valid`  input  1  operand pair `a`/`b` is valid.
- `in_ready`  output  1  block can accept operands (high only in IDLE).
- `a`  input  WIDTH  minuend.
- `b`  input  WIDTH  subtrahend.
- `out_valid`  output  1  result valid (high only in DONE).
- `out_ready`  input  1  consumer accepts result.
- `diff`  output  WIDTH  `a - b` modulo 2^WIDTH.
- `borrow`  output  1  unsigned borrow: 1 iff a < b (unsigned); equals the inverted final carry.
- `zero`, `ovf`  output  1 each  present only with NSUB_FLAGS_EN (see Configuration).

## Operation
- **States**
  - IDLE: `in_ready`=1.
  - RUN: `in_ready`=0, `out_valid`=0.
  - DONE: `out_valid`=1.
- **Transitions**
  - IDLE→RUN on `in_valid && in_ready`.
  - RUN→DONE when the step counter reaches N-1.
  - DONE→IDLE on `out_valid && out_ready`.
- **Accept** (IDLE→RUN edge):
  - Latch `a` into the A shift register and `~b` into the B shift register.
  - Set the carry register to 1 and the step counter to 0.
  - Clear `diff`.
- **Each RUN cycle:**
  - The CLA slice adds the low nibble of A, the low nibble of ~B and the carry register.
  - The sum nibble is shifted into `diff` from the MSB side, so after N steps nibble 0 sits at `diff[3:0]`.
  - The slice carry-out goes into the carry register.
  - A and B shift right by 4.
  - The counter increments.
- **Last step:** `borrow` <= ~carry-out of step N-1.
- **Input gating:** operand changes are ignored outside the accept edge. `in_valid` is ignored in RUN and DONE; there is no overlap of operations.
- **Result hold:** `diff`, `borrow` and the flags hold stable throughout DONE until the handshake, then keep their value in IDLE until the next accept.
- **Reset (any time, including mid-RUN):**
  - State returns to IDLE immediately.
  - `diff`, `borrow`, `zero`, `ovf`, `out_valid` and the counter go to 0, and the carry register to 1.
  - `in_ready` is 1 while in IDLE after reset.
  - Any in-flight operation is discarded without output.
- **Counter:** width is ceil(log2(N)) and the maximum of 1. With WIDTH=4 the operation completes in one RUN cycle.

## Timing
- Latency: `out_valid` rises exactly N clock edges after the accept edge (WIDTH=32: 8 cycles).
- `in_ready` falls on the accept edge. It returns high on the edge that completes the output handshake.
- Minimum initiation interval with `out_ready` held high: N+2 cycles (accept, N RUN steps, 1 DONE cycle, back in IDLE).
- All outputs are registered; there is no combinational path from inputs to outputs.
- Backpressure: DONE persists indefinitely while `out_ready`=0.

## Configuration
- Macro `NSUB_FLAGS_EN`.
- **Defined:**
  - Ports `zero` and `ovf` exist, registered alongside `diff`.
  - `zero`=1 iff `diff`==0. It is tracked incrementally as an OR of the sum nibbles, reset at accept.
  - `ovf`=1 on signed overflow: (a[MSB]≠b[MSB]) && (diff[MSB]≠a[MSB]). The operand MSBs are captured at accept.
- **Undefined:** `zero` and `ovf` ports and their logic are absent; all other behaviour is identical.

## Test plan
- **Basic subtract:** WIDTH=32, a=0x00000010, b=0x00000001, `out_ready`=1 → `diff`=0x0000000F, `borrow`=0; `out_valid` 8 cycles after accept, high for 1 cycle.
- **Underflow:** a=0x00000000, b=0x00000001 → `diff`=0xFFFFFFFF, `borrow`=1, `ovf`=0 (flags build).
- **Flags:**
  - a=0x80000000, b=0x00000001 → `diff`=0x7FFFFFFF, `borrow`=0, `ovf`=1, `zero`=0.
  - a=b=0x12345678 → `diff`=0, `zero`=1, `borrow`=0.
- **Backpressure:** hold `out_ready`=0 for 5 cycles in DONE while driving new `in_valid`=1 operands → `out_valid`, `diff` and `borrow` stay stable and `in_ready`=0. After `out_ready`=1, exactly one result is consumed and the new operands are accepted in IDLE.
- **Reset mid-RUN:** assert `rst_n`=0 at RUN step 4 → all outputs 0 asynchronously and no `out_valid`. After release, `in_ready`=1 and the next operation (a=5, b=3) yields `diff`=2.
- **Back-to-back:** 3 operations with `in_valid` and `out_ready` held high → accepts are spaced 10 cycles apart (WIDTH=32), each result correct, none dropped or duplicated.
